// File: rtl/adder_rshift8bit.sv
// Pipelined divide-by-255 datapath: a fixed add/shift chain computing floor(X/255),
// plus the two combinational leaf primitives it is built from.

module adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s
);
    // Carry-out is intentionally dropped: sums wrap mod 2^32.
    assign s = a + b;
endmodule

module rshift8bit (
    input  logic [31:0] a,
    output logic [31:0] s
);
    assign s = {8'b0, a[31:8]};
endmodule

module adder_rshift8bit #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] x_in,
    output logic         out_valid,
    output logic [W-1:0] y_out
);
    logic [W-1:0] x_q, x_d;
    logic         v1_q;
    logic [W-1:0] y_q, y_d;
    logic         ov_q;

    logic [W-1:0] x1, t1, t2, t3, t4, t5, t6, y_comb;

    // Y = ((((((X+1)>>8)+X1)>>8)+X1)>>8 + X1) >> 8, every sum truncated to W bits.
    adder      u_a0 (.a(x_q), .b(32'd1), .s(x1));
    rshift8bit u_s0 (.a(x1),  .s(t1));
    adder      u_a1 (.a(t1),  .b(x1),    .s(t2));
    rshift8bit u_s1 (.a(t2),  .s(t3));
    adder      u_a2 (.a(t3),  .b(x1),    .s(t4));
    rshift8bit u_s2 (.a(t4),  .s(t5));
    adder      u_a3 (.a(t5),  .b(x1),    .s(t6));
    rshift8bit u_s3 (.a(t6),  .s(y_comb));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (in_valid) x_d = x_in;
        if (v1_q)     y_d = y_comb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q  <= '0;
            v1_q <= 1'b0;
            y_q  <= '0;
            ov_q <= 1'b0;
        end else begin
            x_q  <= x_d;
            v1_q <= in_valid;
            y_q  <= y_d;
            ov_q <= v1_q;
        end
    end

    assign y_out     = y_q;
    assign out_valid = ov_q;
endmodule

// File: tb/tb_adder_rshift8bit.sv
// Directed self-checking bench for adder_rshift8bit: reset, exact/non-multiples,
// wrap boundary, leaf primitives, streaming and mid-flight reset.

module tb_adder_rshift8bit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] x_in;
    logic        out_valid;
    logic [31:0] y_out;

    logic [31:0] la, lb, ls, ra, rs;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    adder_rshift8bit #(.W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x_in      (x_in),
        .out_valid (out_valid),
        .y_out     (y_out)
    );

    adder      u_leaf_add (.a(la), .b(lb), .s(ls));
    rshift8bit u_leaf_shr (.a(ra), .s(rs));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one dividend, then confirm the result lands exactly two edges later.
    task automatic run_one(input string tag, input logic [31:0] x, input logic [31:0] exp);
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = x;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_ov_early"}, {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ov"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_y"}, y_out, exp);
    endtask

    logic [31:0] sx [4];
    logic [31:0] sy [4];

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        x_in     = 32'h1234;
        la = 32'hFFFF_FFFF; lb = 32'd1; ra = 32'hABCD_1234;

        // Reset held two cycles with a live input present.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_y", y_out, 32'd0);
            check("rst_ov", {31'b0, out_valid}, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("rel_y", y_out, 32'd0);
        check("rel_ov", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rel2_ov", {31'b0, out_valid}, 32'd1);
        check("rel2_y", y_out, 32'd18);  // 0x1234 = 4660, 4660/255 = 18

        run_one("x0",     32'd0,     32'd0);
        run_one("x255",   32'd255,   32'd1);
        run_one("x510",   32'd510,   32'd2);
        run_one("x65535", 32'd65535, 32'd257);
        run_one("x254",   32'd254,   32'd0);
        run_one("x1000",  32'd1000,  32'd3);
        run_one("x256",   32'd256,   32'd1);
        run_one("x1",     32'd1,     32'd0);
        run_one("xwrap",  32'hFFFF_FFFF, 32'd0);

        check("leaf_add_wrap", ls, 32'd0);
        check("leaf_shr", rs, 32'h00AB_CD12);
        la = 32'h1234_5678; lb = 32'h0F0F_0F0F;
        #1;
        check("leaf_add", ls, 32'h2143_6587);

        // Streaming: four back-to-back dividends.
        sx[0] = 32'd255; sx[1] = 32'd510; sx[2] = 32'd765; sx[3] = 32'd1020;
        sy[0] = 32'd1;   sy[1] = 32'd2;   sy[2] = 32'd3;   sy[3] = 32'd4;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 2 && i <= 5) begin
                check($sformatf("strm_ov%0d", i - 2), {31'b0, out_valid}, 32'd1);
                check($sformatf("strm_y%0d", i - 2), y_out, sy[i-2]);
            end
            if (i == 6) begin
                check("strm_drop_ov", {31'b0, out_valid}, 32'd0);
                check("strm_hold_y", y_out, 32'd4);
            end
            in_valid = (i < 4);
            x_in     = (i < 4) ? sx[i] : 32'd0;
            @(posedge clk);
        end

        // Mid-flight reset: dividend sampled, reset on the following edge.
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = 32'd510;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_ov", {31'b0, out_valid}, 32'd0);
        check("mid_y", y_out, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("mid_after_ov%0d", i), {31'b0, out_valid}, 32'd0);
            check($sformatf("mid_after_y%0d", i), y_out, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
